// File: rtl/fractal_sync_root_responder.sv
// Root responder of a fractal sync tree: gathers per-port barrier arrivals,
// detects completion per barrier ID and returns registered wake/error pulses.

module fractal_sync_root_port #(
    parameter int LVL_W    = 4,
    parameter int ID_W     = 2,
    parameter int N_ID     = 4,
    parameter int ROOT_LVL = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_sync_i,
    input  logic [LVL_W-1:0] req_lvl_i,
    input  logic [ID_W-1:0]  req_id_i,
    input  logic [N_ID-1:0]  arr_col_i,
    input  logic             wake_emit_i,
    input  logic [ID_W-1:0]  wake_id_i,
    output logic             arrive_o,
    output logic             err_ovf_o,
    output logic             rsp_wake_o,
    output logic             rsp_err_o,
    output logic [LVL_W-1:0] rsp_lvl_o,
    output logic [ID_W-1:0]  rsp_id_o
);
    logic            err, ep_q, ep_eff, emit_err;
    logic [ID_W-1:0] eid_q, eid_eff;

    assign err       = req_sync_i & ((req_lvl_i != LVL_W'(ROOT_LVL)) | arr_col_i[req_id_i]);
    assign arrive_o  = req_sync_i & ~err;
    // A pending error is never overwritten: the newer one is the one lost.
    assign err_ovf_o = err & ep_q;
    assign ep_eff    = ep_q | err;
    assign eid_eff   = ep_q ? eid_q : req_id_i;
    assign emit_err  = ep_eff & ~wake_emit_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ep_q       <= 1'b0;
            eid_q      <= '0;
            rsp_wake_o <= 1'b0;
            rsp_err_o  <= 1'b0;
            rsp_lvl_o  <= '0;
            rsp_id_o   <= '0;
        end else begin
            ep_q       <= ep_eff & wake_emit_i;
            eid_q      <= eid_eff;
            rsp_wake_o <= wake_emit_i;
            rsp_err_o  <= emit_err;
            rsp_id_o   <= wake_emit_i ? wake_id_i : (emit_err ? eid_eff : '0);
            rsp_lvl_o  <= (wake_emit_i | emit_err) ? LVL_W'(ROOT_LVL) : '0;
        end
    end
endmodule

module fractal_sync_root_responder #(
    parameter int N_PORTS  = 2,
    parameter int LVL_W    = 4,
    parameter int ID_W     = 2,
    parameter int ROOT_LVL = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_PORTS-1:0]       req_sync_i,
    input  logic [N_PORTS*LVL_W-1:0] req_lvl_i,
    input  logic [N_PORTS*ID_W-1:0]  req_id_i,
    output logic [N_PORTS-1:0]       rsp_wake_o,
    output logic [N_PORTS-1:0]       rsp_err_o,
    output logic [N_PORTS*LVL_W-1:0] rsp_lvl_o,
    output logic [N_PORTS*ID_W-1:0]  rsp_id_o,
    output logic                     overflow_o
);
    localparam int N_ID = 1 << ID_W;

    if (N_PORTS < 2) begin : g_bad_ports
        $fatal(1, "fractal_sync_root_responder: N_PORTS must be >= 2");
    end
    if (ROOT_LVL < 0 || ROOT_LVL >= (1 << LVL_W)) begin : g_bad_lvl
        $fatal(1, "fractal_sync_root_responder: ROOT_LVL does not fit in LVL_W");
    end

    logic [N_ID-1:0][N_PORTS-1:0] arr_q, arr_d;
    logic [N_PORTS-1:0][N_ID-1:0] arr_col;
    logic [N_ID-1:0]              wp_q, wp_d, done, pend;
    logic [N_PORTS-1:0]           arrive, err_ovf;
    logic                         wake_emit, wake_ovf;
    logic [ID_W-1:0]              wake_id;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        for (genvar k = 0; k < N_ID; k++) begin : g_col
            assign arr_col[p][k] = arr_q[k][p];
        end

        fractal_sync_root_port #(
            .LVL_W   (LVL_W),
            .ID_W    (ID_W),
            .N_ID    (N_ID),
            .ROOT_LVL(ROOT_LVL)
        ) u_port (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req_sync_i (req_sync_i[p]),
            .req_lvl_i  (req_lvl_i[p*LVL_W +: LVL_W]),
            .req_id_i   (req_id_i[p*ID_W +: ID_W]),
            .arr_col_i  (arr_col[p]),
            .wake_emit_i(wake_emit),
            .wake_id_i  (wake_id),
            .arrive_o   (arrive[p]),
            .err_ovf_o  (err_ovf[p]),
            .rsp_wake_o (rsp_wake_o[p]),
            .rsp_err_o  (rsp_err_o[p]),
            .rsp_lvl_o  (rsp_lvl_o[p*LVL_W +: LVL_W]),
            .rsp_id_o   (rsp_id_o[p*ID_W +: ID_W])
        );
    end

    // Completions of this cycle join the pending set directly so that a
    // barrier finishing at cycle t can wake at t+1.
    always_comb begin
        logic [N_PORTS-1:0] nxt;
        arr_d     = arr_q;
        done      = '0;
        wake_id   = '0;
        for (int k = 0; k < N_ID; k++) begin
            nxt = arr_q[k];
            for (int p = 0; p < N_PORTS; p++) begin
                if (arrive[p] && req_id_i[p*ID_W +: ID_W] == ID_W'(k)) nxt[p] = 1'b1;
            end
            done[k]  = &nxt;
            arr_d[k] = done[k] ? '0 : nxt;
        end
        pend      = wp_q | done;
        wake_ovf  = |(wp_q & done);
        wake_emit = |pend;
        for (int k = N_ID - 1; k >= 0; k--) begin
            if (pend[k]) wake_id = ID_W'(k);
        end
        wp_d = pend;
        if (wake_emit) wp_d[wake_id] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arr_q      <= '0;
            wp_q       <= '0;
            overflow_o <= 1'b0;
        end else begin
            arr_q      <= arr_d;
            wp_q       <= wp_d;
            overflow_o <= overflow_o | wake_ovf | (|err_ovf);
        end
    end
endmodule
